// File: rtl/tc_ps_gp_pkg.sv
// Shared constants and encodings for the PS GP0 status-register read path.
package tc_ps_gp_pkg;

  localparam int WTH_ADDR = 32;
  localparam int WTH_ADDL = 10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    GLOBAL  = 3'd0,
    CAPTURE = 3'd1,
    LASER   = 3'd2,
    BUS     = 3'd3,
    OTHER   = 3'd4
  } grp_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/tc_ps_gp_axi_rd.sv
// AXI4-Lite read front end: byte address -> {group, index} word address,
// waits out the read-mux latency, returns the word; unknown groups get SLVERR.
module tc_ps_gp_axi_rd
  import tc_ps_gp_pkg::*;
#(
  parameter int RD_LAT     = 2,
  parameter int NUM_GROUPS = 5,
  parameter int WTH_ADDL   = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s_araddr,
  input  logic [2:0]  s_arprot,
  input  logic        s_arvalid,
  output logic        s_arready,
  output logic [31:0] s_rdata,
  output logic [1:0]  s_rresp,
  output logic        s_rvalid,
  input  logic        s_rready,
  output logic [31:0] rd_addr,
  input  logic [31:0] rd_data,
  output logic [15:0] err_cnt
);

  localparam int WTH_GRP = WTH_ADDR - WTH_ADDL - 2;
  localparam logic [WTH_GRP-1:0] GRP_LIMIT = WTH_GRP'(NUM_GROUPS);

  state_e state, state_nxt;
  logic [3:0]         cnt;
  logic               err_flag;
  logic [WTH_GRP-1:0] grp;
  logic               ar_hs, cap;
  logic               unused_bits;

  assign unused_bits = ^{s_arprot, s_araddr[1:0]};
  assign grp         = s_araddr[WTH_ADDR-1:WTH_ADDL+2];

  // s_arready depends only on state and rst, never on the incoming valids
  assign s_arready = (state == IDLE) && !rst;
  assign s_rvalid  = (state == RESP);
  assign ar_hs     = s_arready && s_arvalid;
  assign cap       = (state == WAIT) && (cnt == 4'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (s_arvalid) state_nxt = WAIT;
      WAIT:    if (cnt == 4'd0) state_nxt = RESP;
      RESP:    if (s_rready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_addr  <= '0;
      err_flag <= 1'b0;
      cnt      <= '0;
      s_rdata  <= '0;
      s_rresp  <= RESP_OKAY;
      err_cnt  <= '0;
    end else if (ar_hs) begin
      rd_addr  <= {2'b00, s_araddr[WTH_ADDR-1:2]};
      err_flag <= (grp >= GRP_LIMIT);
      cnt      <= 4'(RD_LAT);
    end else if (state == WAIT) begin
      if (!cap) begin
        cnt <= cnt - 4'd1;
      end else begin
        // bad groups still pay the full latency so timing doesn't leak the map
        s_rdata <= err_flag ? 32'd0 : rd_data;
        s_rresp <= err_flag ? RESP_SLVERR : RESP_OKAY;
        if (err_flag && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
      end
    end
  end

endmodule
